arbiter4way: RTL

- Round-robin arbiter that shares one Hack memory write/load path among four requesters (CPU, DMA, screen, keyboard loader).
- Produces a one-hot grant and a 2-bit select. The select drives the dmux4way load-routing and mux4way data-select stages of the shared resource.
- Sits between the requesters and the shared RAM bank port. Supports hold-while-requested ownership with an optional forced rotation to prevent starvation.

---
 rtl/arbiter4way.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/arbiter4way.sv
// -----------------------------------------------------------------------------
// arbiter4way
// Round-robin arbiter that shares one memory write/load path among four
// requesters (CPU, DMA, screen, keyboard loader). The owner keeps the grant
// for as long as it holds its request. Optionally, the owner is forced to
// rotate out after MAX_HOLD cycles if someone else is waiting.
//
// Parameters
//   MAX_HOLD : max consecutive grant cycles while another requester waits
//              (0 = unlimited, no forced rotation)
//   CNT_W    : hold counter width, MAX_HOLD must be < 2**CNT_W
//
// Ports
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   req     : request per requester, bit i = requester i (level, never latched)
//   grant   : one-hot registered grant, zero when idle
//   sel     : binary owner index for the dmux4way / mux4way stages
//   busy    : high when any grant bit is set
//   preempt : one-cycle pulse after a forced rotation moved the grant
//
// FSM states
//   state | meaning
//   IDLE  | no grant; sel keeps the previous owner index
//   OWNED | exactly one grant bit set; owner index held in sel
// -----------------------------------------------------------------------------
module arbiter4way #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // With forced rotation the counter parks at MAX_HOLD, so a newcomer
  // triggers rotation on the very first cycle it appears.
  localparam bit ROTATE_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_SAT =
    ROTATE_EN ? CNT_W'(MAX_HOLD) : {CNT_W{1'b1}};

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [1:0]       last;

  logic [1:0] base;
  logic [3:0] cand;
  logic [1:0] idx;
  logic       win_vld;
  logic [1:0] win_idx;
  logic       owner_req;
  logic       at_limit;

  // Winner search. While owned, the owner is the pointer the next search
  // starts from (it becomes "last" at the handoff edge) and is excluded
  // from the candidates, so a forced rotation never re-grants it.
  always_comb begin
    base    = (state == OWNED) ? sel : last;
    cand    = (state == OWNED) ? (req & ~grant) : req;
    idx     = base;
    win_vld = 1'b0;
    win_idx = base;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign owner_req = req[sel];
  assign at_limit  = ROTATE_EN && (hold_cnt == HOLD_SAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      sel      <= 2'b00;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      hold_cnt <= '0;
      last     <= 2'd3;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state    <= OWNED;
            grant    <= 4'b0001 << win_idx;
            sel      <= win_idx;
            busy     <= 1'b1;
            hold_cnt <= CNT_W'(1);
          end
        end
        OWNED: begin
          if (!owner_req) begin
            // Release: hand off in the same edge if anyone else waits.
            last <= sel;
            if (win_vld) begin
              grant    <= 4'b0001 << win_idx;
              sel      <= win_idx;
              hold_cnt <= CNT_W'(1);
            end else begin
              state    <= IDLE;
              grant    <= 4'b0000;
              busy     <= 1'b0;
              hold_cnt <= '0;
            end
          end else if (at_limit && win_vld) begin
            last     <= sel;
            grant    <= 4'b0001 << win_idx;
            sel      <= win_idx;
            hold_cnt <= CNT_W'(1);
            preempt  <= 1'b1;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  a_busy_match : assert property (@(posedge clk) disable iff (!rst_n)
    busy == (grant != 4'b0000));
  a_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));
  a_sel_match : assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> (grant == (4'b0001 << sel)));
  a_preempt_busy : assert property (@(posedge clk) disable iff (!rst_n)
    preempt |-> busy);

endmodule
